// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
//   Shared instruction/data memory handshake between the sequencer and the
//   memory port.
//   mem_req  : request, held high until mem_ack
//   mem_we   : 1 = write (SW), 0 = read
//   mem_sel  : address source, 0 = PC, 1 = ALU result
//   mem_ack  : memory completes the current request this cycle
//   master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface mc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ack);
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB over a
//   single shared memory port. Traps on illegal opcodes and memory timeouts,
//   and counts retired instructions.
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   mem              : memory handshake (master modport)
//   run_i            : fetch enable, sampled in FETCH
//   opcode_i/funct_i : IR[31:26] / IR[5:0]
//   zero_i           : ALU zero flag (EXEC)
//   ir_wr_o .. wb_src_o : datapath enables and mux selects
//   instr_retired_o  : one-cycle pulse in the last cycle of an instruction
//   retired_cnt_o    : wrapping retired-instruction count
//   illegal_o/bus_err_o : sticky trap causes
//   state_o          : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
// ---------------------------------------------------------------------------
module mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned RET_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_sequencer_if.master    mem,
  input  logic              run_i,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic              zero_i,
  output logic              ir_wr_o,
  output logic              pc_wr_o,
  output logic [1:0]        pc_src_o,
  output logic              alu_src_b_o,
  output logic              reg_wr_o,
  output logic [1:0]        reg_dst_o,
  output logic [1:0]        wb_src_o,
  output logic              instr_retired_o,
  output logic [RET_W-1:0]  retired_cnt_o,
  output logic              illegal_o,
  output logic              bus_err_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  // Counter value at which one more unacknowledged cycle means timeout.
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        tmo_q;
  logic               fetch_busy_q;
  logic [RET_W-1:0]   retired_cnt_q;
  logic               illegal_q, bus_err_q;

  logic is_rtype, is_jr, is_rtype_alu, is_j, is_jal, is_beq, is_bne;
  logic is_imm_alu, is_lw, is_sw, legal;
  logic req_c, we_c, sel_c, tmo_hit, tmo_trap;

  always_comb begin
    is_rtype     = (opcode_i == 6'h00);
    is_jr        = is_rtype && (funct_i == 6'h08);
    is_rtype_alu = is_rtype && (funct_i inside {6'h21, 6'h23, 6'h24, 6'h25,
                                                6'h26, 6'h2A, 6'h2B});
    is_j         = (opcode_i == 6'h02);
    is_jal       = (opcode_i == 6'h03);
    is_beq       = (opcode_i == 6'h04);
    is_bne       = (opcode_i == 6'h05);
    is_imm_alu   = (opcode_i inside {6'h08, 6'h09, 6'h0A, 6'h0B,
                                     6'h0D, 6'h0E, 6'h0F});
    is_lw        = (opcode_i == 6'h23);
    is_sw        = (opcode_i == 6'h2B);
    legal        = is_jr | is_rtype_alu | is_j | is_jal | is_beq | is_bne |
                   is_imm_alu | is_lw | is_sw;
  end

  // An ack in the same cycle as the last allowed wait cycle wins.
  assign tmo_hit = !mem.mem_ack && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    req_c       = 1'b0;
    we_c        = 1'b0;
    sel_c       = 1'b0;
    ir_wr_o     = 1'b0;
    pc_wr_o     = 1'b0;
    pc_src_o    = 2'd0;
    alu_src_b_o = 1'b0;
    reg_wr_o    = 1'b0;
    reg_dst_o   = 2'd0;
    wb_src_o    = 2'd0;
    tmo_trap    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Once a fetch has started it is held until ack even if run drops.
        if (run_i || fetch_busy_q) begin
          req_c = 1'b1;
          if (mem.mem_ack) begin
            ir_wr_o = 1'b1;
            pc_wr_o = 1'b1;
            state_d = S_DECODE;
          end else if (tmo_hit) begin
            tmo_trap = 1'b1;
            state_d  = S_TRAP;
          end
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
        end else if (is_j || is_jal) begin
          pc_wr_o  = 1'b1;
          pc_src_o = 2'd2;
          if (is_jal) begin
            reg_wr_o  = 1'b1;
            reg_dst_o = 2'd2;
            wb_src_o  = 2'd2;
          end
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_wr_o  = 1'b1;
          pc_src_o = 2'd3;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_b_o = !(is_rtype || is_beq || is_bne);
        if (is_beq || is_bne) begin
          pc_src_o = 2'd1;
          pc_wr_o  = is_beq ? zero_i : !zero_i;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        sel_c = 1'b1;
        we_c  = is_sw;
        if (mem.mem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          tmo_trap = 1'b1;
          state_d  = S_TRAP;
        end
      end
      S_WB: begin
        reg_wr_o  = 1'b1;
        reg_dst_o = is_rtype ? 2'd1 : 2'd0;
        wb_src_o  = is_lw ? 2'd1 : 2'd0;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign instr_retired_o = (state_q != S_FETCH) && (state_d == S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      tmo_q         <= 16'd0;
      fetch_busy_q  <= 1'b0;
      retired_cnt_q <= '0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Count only unacknowledged request cycles that stay in the same state.
      if (req_c && !mem.mem_ack && (state_d == state_q))
        tmo_q <= tmo_q + 16'd1;
      else
        tmo_q <= 16'd0;
      fetch_busy_q <= (state_q == S_FETCH) && req_c && !mem.mem_ack &&
                      (state_d == S_FETCH);
      if (instr_retired_o)
        retired_cnt_q <= retired_cnt_q + RET_W'(1);
      if ((state_q == S_DECODE) && !legal)
        illegal_q <= 1'b1;
      if (tmo_trap)
        bus_err_q <= 1'b1;
    end
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_sel   = sel_c;
  assign retired_cnt_o = retired_cnt_q;
  assign illegal_o     = illegal_q;
  assign bus_err_o     = bus_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//   Directed bench for mc_sequencer (MEM_TIMEOUT=4, RET_W=4). Each scenario
//   task drives per-cycle vectors and compares a packed view of all per-cycle
//   outputs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_wr, pc_wr, alu_src_b, reg_wr, instr_retired, illegal, bus_err;
  logic [1:0] pc_src, reg_dst, wb_src;
  logic [3:0] retired_cnt;
  logic [2:0] state;
  int errors = 0;
  int checks = 0;

  mc_sequencer_if mif();

  mc_sequencer #(.MEM_TIMEOUT(4), .RET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif), .run_i(run), .opcode_i(opcode),
    .funct_i(funct), .zero_i(zero), .ir_wr_o(ir_wr), .pc_wr_o(pc_wr),
    .pc_src_o(pc_src), .alu_src_b_o(alu_src_b), .reg_wr_o(reg_wr),
    .reg_dst_o(reg_dst), .wb_src_o(wb_src), .instr_retired_o(instr_retired),
    .retired_cnt_o(retired_cnt), .illegal_o(illegal), .bus_err_o(bus_err),
    .state_o(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {state, req, we, sel, ir_wr, pc_wr, pc_src, alu_src_b, reg_wr, reg_dst, wb_src, retired}
  function automatic logic [16:0] outs();
    return {state, mif.mem_req, mif.mem_we, mif.mem_sel, ir_wr, pc_wr, pc_src,
            alu_src_b, reg_wr, reg_dst, wb_src, instr_retired};
  endfunction

  function automatic logic [16:0] mk(input int st, input int req, input int we,
      input int sel, input int ir, input int pcw, input int pcs, input int alub,
      input int rw, input int rd, input int wbs, input int ret);
    return {3'(st), 1'(req), 1'(we), 1'(sel), 1'(ir), 1'(pcw), 2'(pcs),
            1'(alub), 1'(rw), 2'(rd), 2'(wbs), 1'(ret)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    mif.mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 17'd0) begin
      errors++; $display("FAIL reset_outs got=%h exp=%h", outs(), 17'd0);
    end
    checks++;
    if ({retired_cnt, illegal, bus_err} !== 6'd0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {retired_cnt, illegal, bus_err});
    end
    tick();
    $display("reset: state=%0d cnt=%0d", state, retired_cnt);
  endtask

  task automatic test_addu();
    logic [16:0] ev [4];
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[2] = mk(2,0,0,0,0,0,0,0,0,0,0,0);
    ev[3] = mk(4,0,0,0,0,0,0,0,1,1,0,1);
    run = 1'b1; mif.mem_ack = 1'b1; opcode = 6'h00; funct = 6'h21;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL addu_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (retired_cnt !== 4'd1) begin
      errors++; $display("FAIL addu_cnt got=%0d exp=1", retired_cnt);
    end
    tick();
    $display("addu: retired_cnt=%0d", retired_cnt);
  endtask

  task automatic test_lw_wait();
    logic [16:0] ev [10];
    logic [9:0]  av;
    int          ir_count = 0;
    for (int i = 0; i < 3; i++) ev[i] = mk(0,1,0,0,0,0,0,0,0,0,0,0);
    ev[3] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[4] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[5] = mk(2,0,0,0,0,0,0,1,0,0,0,0);
    ev[6] = mk(3,1,0,1,0,0,0,0,0,0,0,0);
    ev[7] = mk(3,1,0,1,0,0,0,0,0,0,0,0);
    ev[8] = mk(3,1,0,1,0,0,0,0,0,0,0,0);
    ev[9] = mk(4,0,0,0,0,0,0,0,1,0,1,1);
    av = 10'b0100111000;  // bit i = ack in cycle i; acks in DECODE/EXEC are ignored
    run = 1'b1; opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 10; i++) begin
      mif.mem_ack = av[i];
      @(negedge clk);
      if (ir_wr) ir_count++;
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL lw_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    run = 1'b0; mif.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (ir_count !== 1 || retired_cnt !== 4'd2 || state !== 3'd0) begin
      errors++;
      $display("FAIL lw_end got ir=%0d cnt=%0d st=%0d exp ir=1 cnt=2 st=0",
               ir_count, retired_cnt, state);
    end
    tick();
    $display("lw: ir_wr pulses=%0d retired_cnt=%0d", ir_count, retired_cnt);
  endtask

  task automatic test_branch();
    logic [16:0] ev [6];
    logic [5:0]  ov [6];
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[2] = mk(2,0,0,0,0,1,1,0,0,0,0,1);  // BEQ taken
    ev[3] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[4] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[5] = mk(2,0,0,0,0,0,1,0,0,0,0,1);  // BNE not taken
    ov[0] = 6'h04; ov[1] = 6'h04; ov[2] = 6'h04;
    ov[3] = 6'h05; ov[4] = 6'h05; ov[5] = 6'h05;
    run = 1'b1; mif.mem_ack = 1'b1; zero = 1'b1; funct = 6'h00;
    for (int i = 0; i < 6; i++) begin
      opcode = ov[i];
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL branch_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    run = 1'b0; zero = 1'b0;
    @(negedge clk);
    checks++;
    if (retired_cnt !== 4'd4) begin
      errors++; $display("FAIL branch_cnt got=%0d exp=4", retired_cnt);
    end
    tick();
    $display("branch: retired_cnt=%0d", retired_cnt);
  endtask

  task automatic test_jal();
    logic [16:0] ev [2];
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,1,2,0,1,2,2,1);
    run = 1'b1; mif.mem_ack = 1'b1; opcode = 6'h03;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL jal_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    run = 1'b0;
    $display("jal: retired_cnt=%0d", retired_cnt);
  endtask

  // ADDI with run dropped right after fetch: completes, then idles in FETCH.
  task automatic test_run_drop();
    logic [16:0] ev [6];
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[2] = mk(2,0,0,0,0,0,0,1,0,0,0,0);
    ev[3] = mk(4,0,0,0,0,0,0,0,1,0,0,1);
    ev[4] = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    ev[5] = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    mif.mem_ack = 1'b1; opcode = 6'h08; funct = 6'h00;
    for (int i = 0; i < 6; i++) begin
      run = (i == 0);
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL rundrop_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    $display("run_drop: retired_cnt=%0d", retired_cnt);
  endtask

  // JR, SW, BNE (zero=0) issued back to back with a zero-wait memory.
  task automatic test_back_to_back();
    logic [16:0] ev [9];
    logic [5:0]  ov [9];
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,1,3,0,0,0,0,1);
    ev[2] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[4] = mk(2,0,0,0,0,0,0,1,0,0,0,0);
    ev[5] = mk(3,1,1,1,0,0,0,0,0,0,0,1);
    ev[6] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[7] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[8] = mk(2,0,0,0,0,1,1,0,0,0,0,1);
    for (int i = 0; i < 9; i++)
      ov[i] = (i < 2) ? 6'h00 : ((i < 6) ? 6'h2B : 6'h05);
    run = 1'b1; mif.mem_ack = 1'b1; zero = 1'b0; funct = 6'h08;
    for (int i = 0; i < 9; i++) begin
      opcode = ov[i];
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL b2b_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    run = 1'b0;
    $display("back_to_back: retired_cnt=%0d", retired_cnt);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    run = 1'b1; mif.mem_ack = 1'b1; opcode = 6'h02;
    for (int i = 0; i < 8; i++) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_cnt = 4'(10 + i);
      checks++;
      if (retired_cnt !== exp_cnt) begin
        errors++; $display("FAIL wrap_j%0d got=%0d exp=%0d", i, retired_cnt, exp_cnt);
      end
    end
    run = 1'b0;
    tick();
    $display("wrap: retired_cnt=%0d", retired_cnt);
  endtask

  task automatic test_timeout();
    logic [16:0] ev [9];
    logic [8:0]  av;
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    ev[2] = mk(2,0,0,0,0,0,0,1,0,0,0,0);
    for (int i = 3; i < 7; i++) ev[i] = mk(3,1,1,1,0,0,0,0,0,0,0,0);
    ev[7] = mk(7,0,0,0,0,0,0,0,0,0,0,0);
    ev[8] = mk(7,0,0,0,0,0,0,0,0,0,0,0);
    av = 9'b110000111;  // no ack while in MEM; acks in TRAP must be ignored
    run = 1'b1; opcode = 6'h2B;
    for (int i = 0; i < 9; i++) begin
      mif.mem_ack = av[i];
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL tmo_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    checks++;
    if (bus_err !== 1'b1 || illegal !== 1'b0 || retired_cnt !== 4'd1) begin
      errors++;
      $display("FAIL tmo_flags got be=%b il=%b cnt=%0d exp be=1 il=0 cnt=1",
               bus_err, illegal, retired_cnt);
    end
    run = 1'b0; mif.mem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || bus_err !== 1'b0 || retired_cnt !== 4'd0) begin
      errors++;
      $display("FAIL tmo_reset got st=%0d be=%b cnt=%0d exp st=0 be=0 cnt=0",
               state, bus_err, retired_cnt);
    end
    tick();
    $display("timeout: bus_err trapped and cleared by reset");
  endtask

  task automatic test_illegal();
    logic [16:0] ev [7];
    logic [6:0]  av, rv;
    ev[0] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[1] = mk(1,0,0,0,0,1,2,0,0,0,0,1);
    ev[2] = mk(0,1,0,0,1,1,0,0,0,0,0,0);
    ev[3] = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    for (int i = 4; i < 7; i++) ev[i] = mk(7,0,0,0,0,0,0,0,0,0,0,0);
    av = 7'b1011111;
    rv = 7'b0101111;
    for (int i = 0; i < 7; i++) begin
      opcode = (i < 2) ? 6'h02 : 6'h3F;
      mif.mem_ack = av[i];
      run = rv[i];
      @(negedge clk);
      checks++;
      if (outs() !== ev[i]) begin
        errors++; $display("FAIL illegal_c%0d got=%h exp=%h", i, outs(), ev[i]);
      end
      tick();
    end
    checks++;
    if (illegal !== 1'b1 || bus_err !== 1'b0 || retired_cnt !== 4'd1) begin
      errors++;
      $display("FAIL illegal_flags got il=%b be=%b cnt=%0d exp il=1 be=0 cnt=1",
               illegal, bus_err, retired_cnt);
    end
    $display("illegal: state=%0d illegal=%b", state, illegal);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_branch();
    test_jal();
    test_run_drop();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
